rx_word_aligner: RTL and testbench
==================================

Name: rx_word_aligner

Overview:
- RX-side stage directly upstream of the PCS receive path.
- Takes raw, unaligned 10-bit words from the PMA deserializer and locates the K28.5 comma at any of 10 bit offsets.
- Locks to the comma's offset and re-slices the stream on symbol boundaries.
- Its Aligned_Data / Data_Valid outputs are the PCS receiver's Collected_Data input.

Parameters:
COMMA_N, 10'b0011111010, K28.5 pattern, RD- form
COMMA_P, 10'b1100000101, K28.5 pattern, RD+ form
MISALIGN_LIMIT, 4, consecutive off-offset commas that force a realign (legal range 1..15)
TIMEOUT_WORDS, 1024, lock timeout in words (used only with WA_LOCK_TIMEOUT_EN)

Ports:
WordClk  in  1  word clock from PMA; all logic on its rising edge
RST_n  in  1  asynchronous active-low reset
Raw_Data  in  10  unaligned deserialized word; bit 9 = earliest received bit
Aligned_Data  out  10  symbol-aligned word; bit 9 = first bit of symbol
Data_Valid  out  1  Aligned_Data is aligned and meaningful
Comma_Det  out  1  Aligned_Data this cycle is K28.5 (either disparity)
Aligned  out  1  lock status
Offset  out  4  locked bit offset, 0..9
Realign  out  1  one-cycle pulse when the lock offset changes while aligned

Behaviour:
Reset:
- Async assert on RST_n low clears all registers, including the internal previous-word register prev_q.
- All outputs are 0 on reset. FSM state = UNALIGNED.

Windowing:
- Every edge: prev_q <= Raw_Data.
- Window W[19:0] = {prev_q, Raw_Data}; W[19] is the oldest bit.
- Candidate k (k = 0..9) = W[19-k : 10-k].
- match[k] = candidate equals COMMA_N or COMMA_P.
- first_k = lowest k with match set.

Latency:
- A word presented at edge t reaches Aligned_Data after edge t+1.
- Fixed 2 cycles; no bubbles once aligned.

FSM, UNALIGNED:
- Aligned = 0, Data_Valid = 0, Comma_Det = 0. Aligned_Data holds its last value.
- On any match: Offset <= first_k, Aligned_Data <= candidate(first_k), Comma_Det <= 1, Data_Valid <= 1, Aligned <= 1, bad_cnt <= 0. Go to ALIGNED.
- Realign stays 0 on this initial lock.

FSM, ALIGNED:
- Every cycle: Aligned_Data <= candidate(Offset), Data_Valid <= 1, Comma_Det <= match[Offset].
- match[Offset] set: bad_cnt <= 0. This takes priority over simultaneous matches at other offsets.
- No match at Offset but a match elsewhere: bad_cnt increments.
- When bad_cnt would reach MISALIGN_LIMIT, in the same edge:
  - Offset <= first_k, Aligned_Data <= candidate(first_k), Comma_Det <= 1
  - Realign <= 1 for one cycle, bad_cnt <= 0
  - Aligned and Data_Valid stay 1.
- No match anywhere: bad_cnt holds.
- bad_cnt is 4 bits and saturates (cannot wrap).

Reset mid-stream:
- Outputs drop to 0 immediately (asynchronous).
- The first comma after release relocks with no history from before reset.

Optional Feature:
Macro WA_LOCK_TIMEOUT_EN.
- Defined:
  - 16-bit idle counter, cleared on every match[Offset] in ALIGNED and on entry to ALIGNED; increments otherwise.
  - When it reaches TIMEOUT_WORDS: go to UNALIGNED; Aligned, Data_Valid and Comma_Det <= 0 on that edge; Offset holds.
  - A realign also clears the counter.
- Undefined: no counter; ALIGNED is left only by reset. Realign is unaffected either way.

Test Plan:
1. RST_n low with Raw_Data toggling -> all outputs 0. After release, words of 10'h155 only -> Aligned stays 0 and Data_Valid stays 0 indefinitely.
2. Offset 3 lock: 10'h01F then 10'h100, then 10'h155 continuously -> two edges after 10'h01F is presented: Aligned = 1, Offset = 3, Aligned_Data = 10'h0FA, Comma_Det = 1, Realign = 0. Next cycle Comma_Det = 0, Data_Valid = 1.
3. Offset 0 lock, both disparities: 10'h0FA, then 10'h305 → each appears on Aligned_Data with Comma_Det = 1 two cycles later; Offset = 0.
4. Locked at offset 0. Three commas at offset 3 → Offset stays 0. A comma at offset 0, then four commas at offset 3 → on the fourth: Offset = 3, Realign high for exactly one cycle, Aligned_Data = 10'h0FA.
5. Locked; assert RST_n low for part of a cycle → outputs clear before the next WordClk edge. After release, a comma at offset 7 → Offset = 7, Realign = 0.
6. With WA_LOCK_TIMEOUT_EN and TIMEOUT_WORDS = 8: lock, then 8 non-comma words → Aligned = 0, Data_Valid = 0. Without the macro, 2000 non-comma words → Aligned remains 1.

Source files
------------

// File: rtl/rx_word_aligner.sv
// rx_word_aligner: finds the K28.5 comma at any of 10 bit offsets in the raw
// PMA word stream, locks to that offset and re-slices the stream on symbol
// boundaries for the PCS receiver.
// Optional feature macro: WA_LOCK_TIMEOUT_EN (drop lock after TIMEOUT_WORDS
// words without an in-place comma).
module rx_word_aligner #(
  parameter logic [9:0]  COMMA_N        = 10'b0011111010,
  parameter logic [9:0]  COMMA_P        = 10'b1100000101,
  parameter int unsigned MISALIGN_LIMIT = 4
`ifdef WA_LOCK_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_WORDS = 1024
`endif
) (
  input  logic       WordClk,
  input  logic       RST_n,
  input  logic [9:0] Raw_Data,
  output logic [9:0] Aligned_Data,
  output logic       Data_Valid,
  output logic       Comma_Det,
  output logic       Aligned,
  output logic [3:0] Offset,
  output logic       Realign
);

  localparam int unsigned W      = 10;
  localparam int unsigned NK     = 10;
  localparam int unsigned NSLOT  = 16;
  localparam int unsigned OFF_W  = 4;
  localparam int unsigned BAD_W  = 4;
`ifdef WA_LOCK_TIMEOUT_EN
  localparam int unsigned IDLE_W = 16;
`endif

  typedef enum logic {
    UNALIGNED = 1'b0,
    ALIGNED   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       prev_q;
  logic [2*W-1:0]     win;
  logic [W-1:0]       cand [NSLOT];
  logic [NSLOT-1:0]   match;
  logic               any_match;
  logic [OFF_W-1:0]   first_k;

  logic [BAD_W-1:0]   bad_q, bad_d;
  logic [W-1:0]       data_d;
  logic               valid_d, comma_d, aligned_d, realign_d;
  logic [OFF_W-1:0]   offset_d;
`ifdef WA_LOCK_TIMEOUT_EN
  logic [IDLE_W-1:0]  idle_q, idle_d;
`endif

  // Slice the 20-bit window at every offset and flag comma hits; slots 10..15 are unused padding.
  always_comb begin
    win = {prev_q, Raw_Data};
    for (int k = 0; k < int'(NSLOT); k++) begin
      cand[k]  = '0;
      match[k] = 1'b0;
    end
    for (int k = 0; k < int'(NK); k++) begin
      cand[k]  = win[2*W-1-k -: W];
      match[k] = (cand[k] == COMMA_N) || (cand[k] == COMMA_P);
    end
    any_match = |match;
    first_k   = '0;
    for (int k = int'(NK) - 1; k >= 0; k--) begin
      if (match[k]) first_k = OFF_W'(k);
    end
  end

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    state_d   = state_q;
    data_d    = Aligned_Data;
    valid_d   = 1'b0;
    comma_d   = 1'b0;
    aligned_d = 1'b0;
    offset_d  = Offset;
    realign_d = 1'b0;
    bad_d     = bad_q;
`ifdef WA_LOCK_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      UNALIGNED: begin
        if (any_match) begin
          state_d   = ALIGNED;
          offset_d  = first_k;
          data_d    = cand[first_k];
          comma_d   = 1'b1;
          valid_d   = 1'b1;
          aligned_d = 1'b1;
          bad_d     = '0;
`ifdef WA_LOCK_TIMEOUT_EN
          idle_d    = '0;
`endif
        end
      end
      ALIGNED: begin
        aligned_d = 1'b1;
        valid_d   = 1'b1;
        data_d    = cand[Offset];
        comma_d   = match[Offset];
        if (match[Offset]) begin
          // An in-place comma wins over commas seen at other offsets.
          bad_d = '0;
`ifdef WA_LOCK_TIMEOUT_EN
          idle_d = '0;
`endif
        end else if (any_match && (32'(bad_q) + 32'd1 >= MISALIGN_LIMIT)) begin
          // Too many off-offset commas in a row: jump to the new offset now.
          offset_d  = first_k;
          data_d    = cand[first_k];
          comma_d   = 1'b1;
          realign_d = 1'b1;
          bad_d     = '0;
`ifdef WA_LOCK_TIMEOUT_EN
          idle_d    = '0;
`endif
        end else begin
          if (any_match && (bad_q != '1)) bad_d = bad_q + BAD_W'(1);
`ifdef WA_LOCK_TIMEOUT_EN
          if (32'(idle_q) + 32'd1 >= TIMEOUT_WORDS) begin
            state_d   = UNALIGNED;
            aligned_d = 1'b0;
            valid_d   = 1'b0;
            comma_d   = 1'b0;
          end else if (idle_q != '1) begin
            idle_d = idle_q + IDLE_W'(1);
          end
`endif
        end
      end
      default: state_d = UNALIGNED;
    endcase
  end

  // State, history word and registered outputs.
  always_ff @(posedge WordClk or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= UNALIGNED;
      prev_q       <= '0;
      bad_q        <= '0;
      Aligned_Data <= '0;
      Data_Valid   <= 1'b0;
      Comma_Det    <= 1'b0;
      Aligned      <= 1'b0;
      Offset       <= '0;
      Realign      <= 1'b0;
`ifdef WA_LOCK_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= Raw_Data;
      bad_q        <= bad_d;
      Aligned_Data <= data_d;
      Data_Valid   <= valid_d;
      Comma_Det    <= comma_d;
      Aligned      <= aligned_d;
      Offset       <= offset_d;
      Realign      <= realign_d;
`ifdef WA_LOCK_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_rx_word_aligner.sv
// Self-checking bench for rx_word_aligner: a behavioural model predicts the
// outputs for every driven word into a scoreboard queue, popped after the edge.
module tb_rx_word_aligner;

  localparam int unsigned LIMIT = 4;
`ifdef WA_LOCK_TIMEOUT_EN
  localparam int unsigned TO_WORDS = 8;
`endif
  localparam logic [9:0] K_N = 10'b0011111010;
  localparam logic [9:0] K_P = 10'b1100000101;

  typedef struct packed {
    logic [9:0] data;
    logic       valid;
    logic       comma;
    logic       aligned;
    logic [3:0] off;
    logic       realign;
  } exp_t;

  logic       word_clk = 1'b0;
  logic       rst_n;
  logic [9:0] raw_data;
  logic [9:0] aligned_data;
  logic       data_valid;
  logic       comma_det;
  logic       aligned;
  logic [3:0] offset;
  logic       realign;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [9:0] m_prev, m_data;
  logic       m_valid, m_comma, m_aligned, m_realign;
  logic [3:0] m_off, m_bad;
  int         m_idle;

`ifdef WA_LOCK_TIMEOUT_EN
  rx_word_aligner #(.MISALIGN_LIMIT(LIMIT), .TIMEOUT_WORDS(TO_WORDS)) u_dut (
    .WordClk     (word_clk),
    .RST_n       (rst_n),
    .Raw_Data    (raw_data),
    .Aligned_Data(aligned_data),
    .Data_Valid  (data_valid),
    .Comma_Det   (comma_det),
    .Aligned     (aligned),
    .Offset      (offset),
    .Realign     (realign)
  );
`else
  rx_word_aligner #(.MISALIGN_LIMIT(LIMIT)) u_dut (
    .WordClk     (word_clk),
    .RST_n       (rst_n),
    .Raw_Data    (raw_data),
    .Aligned_Data(aligned_data),
    .Data_Valid  (data_valid),
    .Comma_Det   (comma_det),
    .Aligned     (aligned),
    .Offset      (offset),
    .Realign     (realign)
  );
`endif

  always #5 word_clk = ~word_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] slc(input logic [19:0] w, input int k);
    return 10'(w >> (10 - k));
  endfunction

  task automatic model_reset();
    m_prev = '0; m_data = '0; m_valid = 1'b0; m_comma = 1'b0;
    m_aligned = 1'b0; m_realign = 1'b0; m_off = '0; m_bad = '0; m_idle = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [9:0] raw);
    logic [19:0] w;
    int          fk;
    logic        at_off;
    exp_t        e;
    w = {m_prev, raw};
    fk = -1;
    at_off = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (slc(w, k) == K_N || slc(w, k) == K_P) begin
        if (fk < 0) fk = k;
        if (m_aligned && k == int'(m_off)) at_off = 1'b1;
      end
    end
    m_prev = raw;
    m_realign = 1'b0;
    if (!m_aligned) begin
      if (fk >= 0) begin
        m_off = 4'(fk); m_data = slc(w, fk); m_comma = 1'b1; m_valid = 1'b1;
        m_aligned = 1'b1; m_bad = '0; m_idle = 0;
      end
    end else begin
      m_data = slc(w, int'(m_off));
      m_comma = at_off;
      if (at_off) begin
        m_bad = '0; m_idle = 0;
      end else if (fk >= 0 && int'(m_bad) + 1 == int'(LIMIT)) begin
        m_off = 4'(fk); m_data = slc(w, fk); m_comma = 1'b1;
        m_realign = 1'b1; m_bad = '0; m_idle = 0;
      end else begin
        if (fk >= 0 && m_bad != 4'hF) m_bad = m_bad + 4'd1;
        m_idle++;
`ifdef WA_LOCK_TIMEOUT_EN
        if (m_idle >= int'(TO_WORDS)) begin
          m_aligned = 1'b0; m_valid = 1'b0; m_comma = 1'b0;
        end
`endif
      end
    end
    e.data = m_data; e.valid = m_valid; e.comma = m_comma;
    e.aligned = m_aligned; e.off = m_off; e.realign = m_realign;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    check("sb_empty", 32'(sb.size() == 0), 32'd0);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("valid",   32'(data_valid), 32'(e.valid));
    check("comma",   32'(comma_det),  32'(e.comma));
    check("aligned", 32'(aligned),    32'(e.aligned));
    check("offset",  32'(offset),     32'(e.off));
    check("realign", 32'(realign),    32'(e.realign));
    if (e.valid) check("data", 32'(aligned_data), 32'(e.data));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},    32'(aligned_data), 32'd0);
    check({tag, "_valid"},   32'(data_valid),   32'd0);
    check({tag, "_comma"},   32'(comma_det),    32'd0);
    check({tag, "_aligned"}, 32'(aligned),      32'd0);
    check({tag, "_offset"},  32'(offset),       32'd0);
    check({tag, "_realign"}, 32'(realign),      32'd0);
  endtask

  task automatic drive_now(input logic [9:0] word);
    raw_data = word;
    model_step(word);
    @(posedge word_clk);
    #1;
    compare_out();
  endtask

  task automatic drive(input logic [9:0] word);
    @(negedge word_clk);
    drive_now(word);
  endtask

  // Short reset pulse inside one low clock phase, then the first word after release.
  task automatic reset_pulse(input logic [9:0] first);
    @(negedge word_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_now(first);
  endtask

  initial begin
    rst_n = 1'b0;
    raw_data = '0;
    model_reset();

    // 1: held in reset with toggling input, then comma-free traffic
    repeat (4) begin
      @(negedge word_clk);
      raw_data = 10'($urandom);
      @(posedge word_clk);
      #1;
      check_all_zero("rst_hold");
    end
    @(negedge word_clk);
    rst_n = 1'b1;
    drive_now(10'h155);
    repeat (19) drive(10'h155);
    check("t1_aligned", 32'(aligned), 32'd0);
    check("t1_valid",   32'(data_valid), 32'd0);

    // 2: lock at offset 3
    drive(10'h01F);
    drive(10'h100);
    check("t2_aligned", 32'(aligned), 32'd1);
    check("t2_offset",  32'(offset), 32'd3);
    check("t2_data",    32'(aligned_data), 32'h0FA);
    check("t2_comma",   32'(comma_det), 32'd1);
    check("t2_realign", 32'(realign), 32'd0);
    drive(10'h155);
    check("t2_comma_next", 32'(comma_det), 32'd0);
    check("t2_valid_next", 32'(data_valid), 32'd1);
    repeat (4) drive(10'h155);

    // 3: offset 0 lock, both disparities
    reset_pulse(10'h0FA);
    drive(10'h305);
    check("t3_data_n",  32'(aligned_data), 32'h0FA);
    check("t3_comma_n", 32'(comma_det), 32'd1);
    check("t3_offset",  32'(offset), 32'd0);
    drive(10'h155);
    check("t3_data_p",  32'(aligned_data), 32'h305);
    check("t3_comma_p", 32'(comma_det), 32'd1);

    // 4: off-offset commas, counter reset by an in-place comma, then realign on the fourth
    repeat (3) begin
      drive(10'h01F);
      drive(10'h100);
    end
    check("t4_offset_hold", 32'(offset), 32'd0);
    drive(10'h0FA);
    repeat (3) begin
      drive(10'h01F);
      drive(10'h100);
    end
    check("t4_offset_pre", 32'(offset), 32'd0);
    check("t4_realign_pre", 32'(realign), 32'd0);
    drive(10'h01F);
    drive(10'h100);
    check("t4_offset",  32'(offset), 32'd3);
    check("t4_realign", 32'(realign), 32'd1);
    check("t4_data",    32'(aligned_data), 32'h0FA);
    check("t4_aligned", 32'(aligned), 32'd1);
    drive(10'h155);
    check("t4_realign_drop", 32'(realign), 32'd0);
    check("t4_offset_keep",  32'(offset), 32'd3);

    // 5: mid-stream reset, relock at offset 7 with no prior history
    reset_pulse(10'h001);
    drive(10'h3D0);
    check("t5_offset",  32'(offset), 32'd7);
    check("t5_realign", 32'(realign), 32'd0);
    check("t5_aligned", 32'(aligned), 32'd1);
    check("t5_data",    32'(aligned_data), 32'h0FA);

    // 6: lock timeout behaviour
`ifdef WA_LOCK_TIMEOUT_EN
    repeat (TO_WORDS - 1) drive(10'h155);
    check("t6_aligned_pre", 32'(aligned), 32'd1);
    drive(10'h155);
    check("t6_aligned", 32'(aligned), 32'd0);
    check("t6_valid",   32'(data_valid), 32'd0);
`else
    repeat (2000) drive(10'h155);
    check("t6_aligned", 32'(aligned), 32'd1);
    check("t6_valid",   32'(data_valid), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
